// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one data-memory port among NREQ requesters (requester 0 = load/store
//   unit, others = debug/DMA masters). Round-robin grant, one transaction in
//   flight, owner locked until the memory answers or the timeout fires.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   m_addr / m_wr_data       per-requester address / write data, slice i = [i*W +: W]
//   m_wr_req / m_rd_req      per-requester requests, held until the matching ready
//   m_wr_ready / m_rd_ready  one-cycle completion pulse to the owner
//   m_rd_data                read data, valid with any m_rd_ready bit, else 0
//   m_err                    one-cycle pulse alongside ready on timeout
//   d_addr / d_wr_data       registered memory address / write data
//   d_wr_req / d_rd_req      registered memory requests
//   d_wr_ready / d_rd_ready  memory completion strobes
//   d_rd_data                memory read data
module dmem_arbiter #(
    parameter int NREQ    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ*AW-1:0]   m_addr,
    input  logic [NREQ*DW-1:0]   m_wr_data,
    input  logic [NREQ-1:0]      m_wr_req,
    input  logic [NREQ-1:0]      m_rd_req,
    output logic [NREQ-1:0]      m_wr_ready,
    output logic [NREQ-1:0]      m_rd_ready,
    output logic [DW-1:0]        m_rd_data,
    output logic [NREQ-1:0]      m_err,
    output logic [AW-1:0]        d_addr,
    output logic [DW-1:0]        d_wr_data,
    output logic                 d_wr_req,
    input  logic                 d_wr_ready,
    output logic                 d_rd_req,
    input  logic                 d_rd_ready,
    input  logic [DW-1:0]        d_rd_data
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr;
    logic            op_wr;
    logic [CW-1:0]   cnt;

    logic [NREQ-1:0] pend;
    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    logic            match;
    logic            timed_out;
    logic            done_ok;
    logic            done_to;
    logic            done;
    logic [NREQ-1:0] owner_hot;
    logic [IW-1:0]   next_rr;

    // Round-robin search: first pending bit starting at rr, wrapping at NREQ.
    always_comb begin
        int unsigned   idx;
        logic [IW-1:0] cand;
        pend        = m_wr_req | m_rd_req;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        cand        = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(rr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = IW'(idx);
            if (!grant_found && pend[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Completion is decided combinationally so the owner sees ready in the
    // same cycle as the memory strobe; reset suppresses any pulse.
    always_comb begin
        match     = op_wr ? d_wr_ready : d_rd_ready;
        timed_out = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT));
        done_ok   = (state == BUSY) && !rst && match;
        done_to   = (state == BUSY) && !rst && !match && timed_out;
        done      = done_ok | done_to;
        owner_hot = NREQ'(1) << owner;
        next_rr   = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;

        m_wr_ready = (done && op_wr)  ? owner_hot : '0;
        m_rd_ready = (done && !op_wr) ? owner_hot : '0;
        m_err      = done_to ? owner_hot : '0;
        m_rd_data  = (done_ok && !op_wr) ? d_rd_data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr        <= '0;
            op_wr     <= 1'b0;
            cnt       <= '0;
            d_addr    <= '0;
            d_wr_data <= '0;
            d_wr_req  <= 1'b0;
            d_rd_req  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_found) begin
                        // Write wins when the owner asserts both; its read stays pending.
                        owner     <= grant_idx;
                        op_wr     <= m_wr_req[grant_idx];
                        d_addr    <= m_addr[grant_idx*AW +: AW];
                        d_wr_data <= m_wr_data[grant_idx*DW +: DW];
                        d_wr_req  <= m_wr_req[grant_idx];
                        d_rd_req  <= !m_wr_req[grant_idx];
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (done) begin
                        d_wr_req <= 1'b0;
                        d_rd_req <= 1'b0;
                        rr       <= next_rr;
                        cnt      <= '0;
                        state    <= IDLE;
                    end else if (TIMEOUT > 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with NREQ=2, TIMEOUT=4. A small memory
//   model answers d_*_req after a programmable latency (registered ready) and
//   can be disabled or overridden with injected strobes.
module tb_dmem_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TO   = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ*AW-1:0]   m_addr = '0;
    logic [NREQ*DW-1:0]   m_wr_data = '0;
    logic [NREQ-1:0]      m_wr_req = '0;
    logic [NREQ-1:0]      m_rd_req = '0;
    logic [NREQ-1:0]      m_wr_ready;
    logic [NREQ-1:0]      m_rd_ready;
    logic [DW-1:0]        m_rd_data;
    logic [NREQ-1:0]      m_err;
    logic [AW-1:0]        d_addr;
    logic [DW-1:0]        d_wr_data;
    logic                 d_wr_req;
    logic                 d_wr_ready;
    logic                 d_rd_req;
    logic                 d_rd_ready;
    logic [DW-1:0]        d_rd_data;

    dmem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .m_addr     (m_addr),
        .m_wr_data  (m_wr_data),
        .m_wr_req   (m_wr_req),
        .m_rd_req   (m_rd_req),
        .m_wr_ready (m_wr_ready),
        .m_rd_ready (m_rd_ready),
        .m_rd_data  (m_rd_data),
        .m_err      (m_err),
        .d_addr     (d_addr),
        .d_wr_data  (d_wr_data),
        .d_wr_req   (d_wr_req),
        .d_wr_ready (d_wr_ready),
        .d_rd_req   (d_rd_req),
        .d_rd_ready (d_rd_ready),
        .d_rd_data  (d_rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: ready rises mem_lat cycles after the request is first seen.
    bit          mem_rd_en = 1'b1;
    bit          mem_wr_en = 1'b1;
    int          mem_lat   = 1;
    logic [31:0] mem_rdata = '0;
    logic        spur_rd   = 1'b0;
    logic        spur_wr   = 1'b0;
    logic        mem_rd_rdy = 1'b0;
    logic        mem_wr_rdy = 1'b0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (d_rd_req && !mem_rd_rdy && mem_rd_en) begin
            rd_cnt     <= rd_cnt + 1;
            mem_rd_rdy <= (rd_cnt + 1 == mem_lat);
        end else begin
            rd_cnt     <= 0;
            mem_rd_rdy <= 1'b0;
        end
        if (d_wr_req && !mem_wr_rdy && mem_wr_en) begin
            wr_cnt     <= wr_cnt + 1;
            mem_wr_rdy <= (wr_cnt + 1 == mem_lat);
        end else begin
            wr_cnt     <= 0;
            mem_wr_rdy <= 1'b0;
        end
    end

    assign d_rd_ready = mem_rd_rdy | spur_rd;
    assign d_wr_ready = mem_wr_rdy | spur_wr;
    assign d_rd_data  = mem_rdata;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Advance until some ready bit is seen, bounded.
    task automatic wait_ready(input int bound);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((m_wr_ready | m_rd_ready) == '0 && n < bound);
        check("ready_seen", 64'(|(m_wr_ready | m_rd_ready)), 64'd1);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] wd0;
    logic [31:0] wd1;
    int          last;
    bit          exp1;

    initial begin
        // Reset state
        do_reset();
        check("rst_d_addr",   64'(d_addr), 64'h0);
        check("rst_d_req",    64'({d_wr_req, d_rd_req}), 64'h0);
        check("rst_m_ready",  64'({m_wr_ready, m_rd_ready, m_err}), 64'h0);
        check("rst_rd_data",  64'(m_rd_data), 64'h0);

        // Single read, memory latency 2
        mem_lat   = 2;
        mem_rdata = 32'hDEADBEEF;
        m_addr[0 +: AW] = 32'h100;
        m_rd_req  = 2'b01;
        tick();
        check("rd_req_c1",    64'(d_rd_req), 64'd1);
        check("rd_addr_c1",   64'(d_addr), 64'h100);
        check("rd_nordy_c1",  64'(m_rd_ready), 64'h0);
        tick();
        check("rd_nordy_c2",  64'(m_rd_ready), 64'h0);
        tick();
        check("rd_rdy_c3",    64'(m_rd_ready), 64'h1);
        check("rd_data_c3",   64'(m_rd_data), 64'hDEADBEEF);
        check("rd_err_c3",    64'(m_err), 64'h0);
        m_rd_req = '0;
        tick();
        check("rd_drop_c4",   64'(d_rd_req), 64'd0);
        check("rd_data_idle", 64'(m_rd_data), 64'h0);

        // Contention: both write every cycle, grants alternate from 0
        do_reset();
        mem_lat = 1;
        wd0 = 32'hA000_0000;
        wd1 = 32'hB000_0000;
        m_addr    = {32'h2000_0004, 32'h2000_0000};
        m_wr_data = {wd1, wd0};
        m_wr_req  = 2'b11;
        last = 0;
        for (int t = 0; t < 20; t++) begin
            exp1 = (t % 2) == 1;
            wait_ready(10);
            check("cont_grant", 64'(m_wr_ready), exp1 ? 64'h2 : 64'h1);
            check("cont_data",  64'(d_wr_data), exp1 ? 64'(wd1) : 64'(wd0));
            if (t > 0) check("cont_period", 64'(cyc - last), 64'd3);
            last = cyc;
            if (exp1) wd1 = wd1 + 1;
            else      wd0 = wd0 + 1;
            m_wr_data = {wd1, wd0};
        end
        m_wr_req = '0;
        tick();

        // Timeout on requester 1, memory silent
        mem_rd_en = 1'b0;
        mem_rdata = 32'hFFFF_0000;
        m_addr[AW +: AW] = 32'h200;
        m_rd_req = 2'b10;
        tick();
        check("to_req_c1",  64'(d_rd_req), 64'd1);
        check("to_addr_c1", 64'(d_addr), 64'h200);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check("to_quiet", 64'({m_rd_ready, m_err}), 64'h0);
        end
        tick();
        check("to_rdy",  64'(m_rd_ready), 64'h2);
        check("to_err",  64'(m_err), 64'h2);
        check("to_data", 64'(m_rd_data), 64'h0);
        m_rd_req = '0;
        tick();
        check("to_idle", 64'({d_rd_req, m_err}), 64'h0);
        mem_rd_en = 1'b1;

        // Write and read from requester 0 plus a read from requester 1
        m_addr    = {32'h3000_0001, 32'h3000_0000};
        m_wr_data = {32'h0, 32'h5555};
        m_wr_req  = 2'b01;
        m_rd_req  = 2'b11;
        wait_ready(10);
        check("wr1_wr", 64'(m_wr_ready), 64'h1);
        check("wr1_rd", 64'(m_rd_ready), 64'h0);
        check("wr1_data", 64'(d_wr_data), 64'h5555);
        m_wr_req  = '0;
        mem_rdata = 32'h1111;
        wait_ready(10);
        check("wr2_rd",   64'(m_rd_ready), 64'h2);
        check("wr2_data", 64'(m_rd_data), 64'h1111);
        check("wr2_addr", 64'(d_addr), 64'h3000_0001);
        m_rd_req  = 2'b01;
        mem_rdata = 32'h2222;
        wait_ready(10);
        check("wr3_rd",   64'(m_rd_ready), 64'h1);
        check("wr3_data", 64'(m_rd_data), 64'h2222);
        check("wr3_addr", 64'(d_addr), 64'h3000_0000);
        m_rd_req = '0;
        tick();

        // Reset while busy
        mem_rd_en = 1'b0;
        m_addr[AW +: AW] = 32'h300;
        m_rd_req = 2'b10;
        tick();
        check("ro_busy", 64'(d_rd_req), 64'd1);
        tick();
        rst = 1'b1;
        m_addr[0 +: AW] = 32'h400;
        m_rd_req = 2'b11;
        #1;
        check("ro_during", 64'({m_rd_ready, m_err}), 64'h0);
        tick();
        check("ro_after_req",  64'({d_wr_req, d_rd_req}), 64'h0);
        check("ro_after_addr", 64'(d_addr), 64'h0);
        check("ro_after_rdy",  64'({m_rd_ready, m_wr_ready, m_err}), 64'h0);
        rst = 1'b0;
        tick();
        check("ro_grant_addr", 64'(d_addr), 64'h400);
        check("ro_grant_req",  64'(d_rd_req), 64'd1);
        mem_rd_en = 1'b1;
        wait_ready(10);
        check("ro_grant_rdy", 64'(m_rd_ready), 64'h1);
        m_rd_req = '0;
        tick();
        tick();

        // Spurious ready in IDLE and during a write
        mem_rdata = 32'hCAFE;
        spur_rd = 1'b1;
        #1;
        check("sp_idle_rdy",  64'({m_rd_ready, m_wr_ready}), 64'h0);
        check("sp_idle_data", 64'(m_rd_data), 64'h0);
        tick();
        spur_rd   = 1'b0;
        mem_wr_en = 1'b0;
        m_wr_data[0 +: DW] = 32'h7777;
        m_wr_req  = 2'b01;
        tick();
        check("sp_wr_req", 64'(d_wr_req), 64'd1);
        spur_rd = 1'b1;
        #1;
        check("sp_wr_rd", 64'({m_rd_ready, m_wr_ready}), 64'h0);
        tick();
        spur_rd = 1'b0;
        spur_wr = 1'b1;
        #1;
        check("sp_wr_done", 64'(m_wr_ready), 64'h1);
        check("sp_wr_data", 64'(d_wr_data), 64'h7777);
        m_wr_req = '0;
        tick();
        spur_wr = 1'b0;
        #1;
        check("sp_wr_drop", 64'({d_wr_req, m_wr_ready}), 64'h0);
        mem_wr_en = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
